pkt_deframer: RTL

//  Downstream consumer of the request-manager TX stream. Each packet arriving on AXIS_IN is one

---
 rtl/pkt_deframer_if.sv | 42 ++++
 rtl/pkt_deframer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pkt_deframer_if.sv
// ----------------------------------------------------------------------------
// pkt_deframer_if
//   Stream bundle for pkt_deframer: the framed input stream (header, payload,
//   footer) and the deframed payload output stream.
//
//   Signals
//     in_tdata   [DATA_W-1:0]  framed packet beats
//     in_tvalid                input beat valid
//     in_tready                deframer can accept input beat
//     out_tdata  [DATA_W-1:0]  payload beats only
//     out_tuser  [ID_W-1:0]    request ID of the packet being forwarded
//     out_tlast                final payload beat of a packet
//     out_tvalid               output beat valid
//     out_tready               downstream can accept output beat
//
//   Modports
//     master : environment side (drives input stream, backpressures output)
//     slave  : deframer side
// ----------------------------------------------------------------------------
interface pkt_deframer_if #(
   parameter int DATA_W = 256,
   parameter int ID_W   = 32
);
   logic [DATA_W-1:0] in_tdata;
   logic              in_tvalid;
   logic              in_tready;
   logic [DATA_W-1:0] out_tdata;
   logic [ID_W-1:0]   out_tuser;
   logic              out_tlast;
   logic              out_tvalid;
   logic              out_tready;

   modport master (
      output in_tdata, in_tvalid, out_tready,
      input  in_tready, out_tdata, out_tuser, out_tlast, out_tvalid
   );

   modport slave (
      input  in_tdata, in_tvalid, out_tready,
      output in_tready, out_tdata, out_tuser, out_tlast, out_tvalid
   );
endinterface

// File: rtl/pkt_deframer.sv
// ----------------------------------------------------------------------------
// pkt_deframer
//   Consumes packets of the form  header(ID) / DATA_BEATS payload / footer(ID),
//   strips header and footer, and forwards the payload with TLAST on the last
//   beat and the request ID on TUSER. The footer ID is compared against the
//   header ID; per-packet status pulses and running counters are reported.
//
//   Optional feature (macro PKT_DEFRAMER_SEQ_CHECK_EN): checks that each header
//   ID is the previous header ID + 1 and reports SEQ_ERR / SEQ_COUNT.
//
//   Ports
//     clk        clock
//     reset      asynchronous reset, active-high
//     axis       pkt_deframer_if.slave (input and output streams)
//     pkt_done   1-cycle pulse when a footer is accepted
//     pkt_err    1-cycle pulse with pkt_done when footer ID != header ID
//     pkt_count  packets completed, wrapping
//     err_count  footer mismatches, saturating at 0xFFFF
//     seq_err    (macro only) 1-cycle pulse on header ID sequence break
//     seq_count  (macro only) sequence breaks, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module pkt_deframer #(
   parameter int DATA_W     = 256,
   parameter int ID_W       = 32,
   parameter int DATA_BEATS = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   pkt_deframer_if.slave        axis,
   output logic                 pkt_done,
   output logic                 pkt_err,
   output logic [31:0]          pkt_count,
`ifdef PKT_DEFRAMER_SEQ_CHECK_EN
   output logic                 seq_err,
   output logic [15:0]          seq_count,
`endif
   output logic [15:0]          err_count
);

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_FTR  = 2'd2;

   localparam logic [7:0] LAST_BEAT = 8'(DATA_BEATS - 1);

   logic [1:0]        state_reg;
   logic [ID_W-1:0]   req_id_reg;
   logic [7:0]        beat_cnt_reg;
   logic [DATA_W-1:0] out_tdata_reg;
   logic [ID_W-1:0]   out_tuser_reg;
   logic              out_tlast_reg;
   logic              out_tvalid_reg;
   logic              pkt_done_reg;
   logic              pkt_err_reg;
   logic [31:0]       pkt_count_reg;
   logic [15:0]       err_count_reg;

   logic              in_tready_next;
   logic              in_hs;
   logic              out_hs;
   logic [ID_W-1:0]   in_id;

   assign in_id  = axis.in_tdata[ID_W-1:0];
   assign in_hs  = axis.in_tvalid & in_tready_next;
   assign out_hs = out_tvalid_reg & axis.out_tready;

   // Payload is only accepted when the output register is free or draining
   // this cycle; header and footer never touch the output register.
   always_comb begin
      in_tready_next = 1'b1;
      if (state_reg == ST_DATA)
         in_tready_next = ~out_tvalid_reg | axis.out_tready;
   end

`ifdef PKT_DEFRAMER_SEQ_CHECK_EN
   logic [ID_W-1:0] prev_id_reg;
   logic            prev_seen_reg;
   logic            seq_err_reg;
   logic [15:0]     seq_count_reg;

   // The first header after reset only seeds prev_id.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_id_reg   <= '0;
         prev_seen_reg <= 1'b0;
         seq_err_reg   <= 1'b0;
         seq_count_reg <= '0;
      end else begin
         seq_err_reg <= 1'b0;
         if (state_reg == ST_HDR && in_hs) begin
            prev_id_reg   <= in_id;
            prev_seen_reg <= 1'b1;
            if (prev_seen_reg && (in_id != ID_W'(prev_id_reg + 1'b1))) begin
               seq_err_reg <= 1'b1;
               if (seq_count_reg != 16'hFFFF)
                  seq_count_reg <= seq_count_reg + 16'd1;
            end
         end
      end
   end

   assign seq_err   = seq_err_reg;
   assign seq_count = seq_count_reg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_HDR;
         req_id_reg     <= '0;
         beat_cnt_reg   <= '0;
         out_tdata_reg  <= '0;
         out_tuser_reg  <= '0;
         out_tlast_reg  <= 1'b0;
         out_tvalid_reg <= 1'b0;
         pkt_done_reg   <= 1'b0;
         pkt_err_reg    <= 1'b0;
         pkt_count_reg  <= '0;
         err_count_reg  <= '0;
      end else begin
         pkt_done_reg <= 1'b0;
         pkt_err_reg  <= 1'b0;

         // Drain; a payload load below in the same cycle takes precedence.
         if (out_hs)
            out_tvalid_reg <= 1'b0;

         case (state_reg)
            ST_HDR: begin
               if (in_hs) begin
                  req_id_reg   <= in_id;
                  beat_cnt_reg <= '0;
                  state_reg    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (in_hs) begin
                  out_tdata_reg  <= axis.in_tdata;
                  out_tuser_reg  <= req_id_reg;
                  out_tlast_reg  <= (beat_cnt_reg == LAST_BEAT);
                  out_tvalid_reg <= 1'b1;
                  beat_cnt_reg   <= beat_cnt_reg + 8'd1;
                  if (beat_cnt_reg == LAST_BEAT)
                     state_reg <= ST_FTR;
               end
            end
            ST_FTR: begin
               if (in_hs) begin
                  pkt_done_reg  <= 1'b1;
                  pkt_count_reg <= pkt_count_reg + 32'd1;
                  if (in_id != req_id_reg) begin
                     pkt_err_reg <= 1'b1;
                     if (err_count_reg != 16'hFFFF)
                        err_count_reg <= err_count_reg + 16'd1;
                  end
                  state_reg <= ST_HDR;
               end
            end
            default: state_reg <= ST_HDR;
         endcase
      end
   end

   assign axis.in_tready  = in_tready_next;
   assign axis.out_tdata  = out_tdata_reg;
   assign axis.out_tuser  = out_tuser_reg;
   assign axis.out_tlast  = out_tlast_reg;
   assign axis.out_tvalid = out_tvalid_reg;
   assign pkt_done        = pkt_done_reg;
   assign pkt_err         = pkt_err_reg;
   assign pkt_count       = pkt_count_reg;
   assign err_count       = err_count_reg;

endmodule
